mul_div_iter: RTL and testbench
===============================

MUL_DIV_ITER -- requirements
Module: mul_div_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled only at accept.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled only at accept.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled only at accept.
REQ-007 start_i  input  1  request; must stay high until ready_o is observed.
REQ-008 annul_i  input  1  cancel in-flight operation.
REQ-009 result_o  output  2*WIDTH  {remainder, quotient}; remainder in upper WIDTH bits.
REQ-010 ready_o  output  1  result_o valid.
REQ-011 busy_o  output  1  operation in progress (state RUN or BYZERO).
REQ-012 div0_o  output  1  divisor was zero; qualified by ready_o.

Function
REQ-013 States: IDLE, RUN, BYZERO, DONE; encoding is free.
REQ-014 Accept: an edge in IDLE with start_i=1 and annul_i=0 moves to BYZERO if opdata2_i==0, else to RUN.
REQ-015 At accept, latch signed_div_i, sign of opdata1_i, sign of opdata1_i XOR opdata2_i, and operand magnitudes (negate only when signed and MSB set); cycle counter cleared.
REQ-016 Operands, including signed_div_i, are not re-sampled after accept; input changes during RUN do not affect the result.
REQ-017 RUN: one restoring shift-subtract step per edge, WIDTH steps total, using a WIDTH+1-bit trial subtract; quotient bit = 1 when the trial result is non-negative.
REQ-018 The edge after the WIDTH-th step applies sign correction, registers result_o, and moves to DONE.
REQ-019 Latency: ready_o rises exactly WIDTH+2 edges after the accept edge (RUN) or 2 edges after it (BYZERO).
REQ-020 Sign rules, signed mode: quotient negated when the operand signs differ; remainder takes the dividend's sign; unsigned mode has no correction.
REQ-021 Signed MIN / -1: quotient = MIN (wraps), remainder = 0, no flag.
REQ-022 BYZERO: next edge moves to DONE with result_o = 0, div0_o = 1.
REQ-023 DONE: ready_o=1; result_o and div0_o held stable; remain in DONE while start_i=1; start_i=0 returns to IDLE next edge.
REQ-024 IDLE entry from DONE clears ready_o, div0_o and result_o to 0; a new accept needs at least one IDLE cycle.
REQ-025 annul_i=1 in RUN or BYZERO: next edge moves to IDLE; ready_o never asserted for that operation; result_o unchanged from 0.
REQ-026 annul_i in DONE is ignored; annul_i=1 in IDLE blocks accept.
REQ-027 busy_o = 1 exactly in RUN and BYZERO.
REQ-028 rst has priority over every other event, including mid-RUN and DONE.

Reset
REQ-029 On rst: state IDLE; result_o=0, ready_o=0, busy_o=0, div0_o=0; counter and datapath registers cleared.
REQ-030 First accept possible on the first edge with rst=0.

Verification
REQ-031 WIDTH=32, unsigned 100/7 -> after 34 edges ready_o=1, result_o={32'd2, 32'd14}, div0_o=0.
REQ-032 WIDTH=32, signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-033 WIDTH=32, signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 5/0 -> ready_o after 2 edges, div0_o=1, result_o=0.
REQ-034 annul_i pulsed 10 edges after accept -> IDLE next edge, ready_o stays 0; change operands during RUN -> result matches the latched operands.
REQ-035 WIDTH=8, unsigned 200/3 -> result_o={8'd2, 8'd66} after 10 edges; hold start_i 5 extra cycles -> output stable; drop start_i -> ready_o=0 next edge.
REQ-036 rst asserted mid-RUN -> all outputs 0 next edge; a fresh accept afterwards gives correct results.

Source files
------------

// File: rtl/mul_div_iter.sv
// mul_div_iter -- iterative restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   signed_div_i    1 = two's-complement divide, 0 = unsigned (sampled at accept)
//   opdata1_i       dividend (sampled at accept)
//   opdata2_i       divisor  (sampled at accept)
//   start_i         request; held high until ready_o is seen
//   annul_i         cancel the operation in flight
//   result_o        {remainder, quotient}
//   ready_o         result_o / div0_o valid
//   busy_o          operation in progress
//   div0_o          divisor was zero (qualified by ready_o)
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div0_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, BYZERO, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sdiv_q, sdiv_d;       // signed mode latched at accept
  logic               neg_q, neg_d;         // dividend sign
  logic               diff_q, diff_d;       // operand signs differ
  logic [WIDTH-1:0]   dvs_q, dvs_d;         // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;         // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;         // dividend shifts out, quotient shifts in
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               div0_q, div0_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Magnitudes: negate only in signed mode with the MSB set. |MIN| comes out
  // as 2^(WIDTH-1), which is exact when read unsigned.
  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (WIDTH'(0) - opdata1_i) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (WIDTH'(0) - opdata2_i) : opdata2_i;

  // The partial remainder is always below the divisor, so the shifted value
  // fits WIDTH+1 bits and the trial MSB is a reliable borrow/sign bit.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit  = ~trial[WIDTH];

  assign quo_fix = (sdiv_q && diff_q) ? (WIDTH'(0) - quo_q) : quo_q;
  assign rem_fix = (sdiv_q && neg_q)  ? (WIDTH'(0) - rem_q) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sdiv_d   = sdiv_q;
    neg_d    = neg_q;
    diff_d   = diff_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    div0_d   = div0_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          sdiv_d  = signed_div_i;
          neg_d   = opdata1_i[WIDTH-1];
          diff_d  = opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
          dvs_d   = mag2;
          quo_d   = mag1;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? BYZERO : RUN;
        end
      end
      RUN: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(WIDTH)) begin
          result_d = {rem_fix, quo_fix};
          div0_d   = 1'b0;
          state_d  = DONE;
        end else begin
          rem_d = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], qbit};
          cnt_d = cnt_q + CW'(1);
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          result_d = '0;
          div0_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // annul_i has no effect here; only dropping start_i releases the result.
        if (!start_i) begin
          result_d = '0;
          div0_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sdiv_q   <= 1'b0;
      neg_q    <= 1'b0;
      diff_q   <= 1'b0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sdiv_q   <= sdiv_d;
      neg_q    <= neg_d;
      diff_q   <= diff_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      div0_q   <= div0_d;
    end
  end

  assign result_o = result_q;
  assign div0_o   = div0_q;
  assign ready_o  = (state_q == DONE);
  assign busy_o   = (state_q == RUN) || (state_q == BYZERO);

endmodule

// File: tb/tb_mul_div_iter.sv
// Testbench for mul_div_iter: a 32-bit and an 8-bit instance share operand
// buses; sel8 chooses which one receives start_i for a transaction.
module tb_mul_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sgn = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic start = 1'b0;
  logic annul = 1'b0;
  logic sel8 = 1'b0;

  logic [63:0] res32;
  logic [15:0] res8;
  logic rdy32, busy32, div032, rdy8, busy8, div08;
  logic start32, start8;
  logic [63:0] res_m;
  logic rdy_m, busy_m, div0_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign start32 = start & ~sel8;
  assign start8  = start & sel8;
  assign res_m   = sel8 ? {48'b0, res8} : res32;
  assign rdy_m   = sel8 ? rdy8 : rdy32;
  assign busy_m  = sel8 ? busy8 : busy32;
  assign div0_m  = sel8 ? div08 : div032;

  mul_div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start32), .annul_i(annul), .result_o(res32), .ready_o(rdy32),
    .busy_o(busy32), .div0_o(div032)
  );

  mul_div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1[7:0]), .opdata2_i(op2[7:0]),
    .start_i(start8), .annul_i(annul), .result_o(res8), .ready_o(rdy8),
    .busy_o(busy8), .div0_o(div08)
  );

  // Reference: plain integer division on sign- or zero-extended operands.
  // SV '/' truncates toward zero and '%' takes the dividend's sign.
  function automatic logic [63:0] ref_div(input int w, input bit s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask;
    longint sa, sb, q, r;
    logic [63:0] uq, ur;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'({32'b0, a} & mask);
    sb = longint'({32'b0, b} & mask);
    if (sb == 0) return 64'd0;
    if (s) begin
      sa = (sa <<< (64 - w)) >>> (64 - w);
      sb = (sb <<< (64 - w)) >>> (64 - w);
    end
    q = sa / sb;
    r = sa % sb;
    uq = q;
    ur = r;
    return ((ur & mask) << w) | (uq & mask);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full transaction; operands are scrambled right after accept to show
  // they were latched. hold = extra DONE cycles with start still high.
  task automatic do_op(input bit w8, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int w, n, lat_exp;
    bit got;
    logic [63:0] exp, held;
    w = w8 ? 8 : 32;
    exp = ref_div(w, s, a, b);
    lat_exp = ((({32'b0, b}) & ((64'd1 << w) - 64'd1)) == 64'd0) ? 2 : w + 2;
    @(negedge clk);
    sel8 = w8; sgn = s; op1 = a; op2 = b; start = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        check("busy_after_accept", {63'b0, busy_m}, 64'd1);
        sgn = 1'($urandom); op1 = $urandom; op2 = $urandom;
      end
      if (rdy_m) got = 1'b1;
    end
    check("latency", 64'(n), 64'(lat_exp));
    check("result", res_m, exp);
    check("div0", {63'b0, div0_m}, {63'b0, (lat_exp == 2)});
    $display("op w=%0d s=%0d a=%h b=%h res=%h div0=%0d edges=%0d",
             w, s, a, b, res_m, div0_m, n);
    held = res_m;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", res_m, held);
      check("hold_ready", {63'b0, rdy_m}, 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("release", {res_m, rdy_m, div0_m, busy_m}, 68'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {res32, rdy32, busy32, div032, res8, rdy8, busy8, div08}, 86'd0);
    @(negedge clk);
    rst = 1'b0;
    // First accept on the very first edge out of reset.
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 2);
    do_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    do_op(1'b1, 1'b0, 32'd200, 32'd3, 5);
    do_op(1'b1, 1'b1, 32'h80, 32'hFF, 0);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // Annul mid-run: back to IDLE, no ready for that operation.
    @(negedge clk);
    sel8 = 1'b0; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd9; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_idle", {res_m, rdy_m, div0_m, busy_m}, 68'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_no_ready", {63'b0, rdy_m}, 64'd0);

    // Annul held in IDLE blocks accept.
    @(negedge clk);
    start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    check("annul_blocks_accept", {63'b0, busy_m}, 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;

    // Reset mid-run, then a fresh operation.
    @(negedge clk);
    op1 = 32'd12345; op2 = 32'd17; start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_midrun", {res_m, rdy_m, div0_m, busy_m}, 68'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    do_op(1'b0, 1'b0, 32'd12345, 32'd17, 0);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 2) == 0) a = 32'($urandom_range(0, 1000));
      do_op(1'b0, 1'($urandom), a, b, 0);
    end
    for (int k = 0; k < 20; k++) begin
      do_op(1'b1, 1'($urandom), $urandom, 32'($urandom_range(0, 255)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
